// File: rtl/wb_char_ram.sv
// wb_char_ram: text-mode character/attribute store.
//
// The CPU reaches the store through a Wishbone register window. A pointer
// register selects one screen cell, and CHAR/ATTR read or write that cell.
// CHAR accesses can optionally advance the pointer. A clear engine fills
// every cell with a sampled fill pair. A separate read port serves the video
// block with a fixed one-cycle latency.
//
// Ports:
//   clk            system clock, shared by the bus and video sides
//   rst            asynchronous active-high reset
//   wb_adr_i       register address; only bits [3:0] are decoded
//   wb_dat_i       write data
//   wb_dat_o       read data; valid in the ack cycle, held until the next read
//   wb_cyc_i       bus cycle
//   wb_stb_i       strobe
//   wb_we_i        write enable
//   wb_ack_o       one-cycle acknowledge, two cycles after acceptance
//   text_char_addr video cell address
//   text_char_data character code at text_char_addr, one cycle later
//   text_attr_data attribute at text_char_addr, one cycle later
//   busy           clear engine running

module wb_char_ram #(
    parameter int COLS = 80,
    parameter int ROWS = 30
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  wb_adr_i,
    input  logic [7:0]  wb_dat_i,
    output logic [7:0]  wb_dat_o,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    output logic        wb_ack_o,
    input  logic [11:0] text_char_addr,
    output logic [7:0]  text_char_data,
    output logic [7:0]  text_attr_data,
    output logic        busy
);

    localparam int          CELLS     = COLS * ROWS;
    localparam logic [11:0] CELLS_W   = 12'(CELLS);
    localparam logic [11:0] LAST_CELL = 12'(CELLS - 1);
    localparam logic [3:0]  VERSION   = 4'h1;

    localparam logic [3:0] A_PTR_LO    = 4'h0;
    localparam logic [3:0] A_PTR_HI    = 4'h1;
    localparam logic [3:0] A_CHAR      = 4'h2;
    localparam logic [3:0] A_ATTR      = 4'h3;
    localparam logic [3:0] A_CTRL      = 4'h4;
    localparam logic [3:0] A_STATUS    = 4'h5;
    localparam logic [3:0] A_FILL_CHAR = 4'h6;
    localparam logic [3:0] A_FILL_ATTR = 4'h7;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_t;

    // Cell storage; intentionally not reset.
    logic [7:0] char_mem_r [CELLS];
    logic [7:0] attr_mem_r [CELLS];

    // Bus pipeline: stage 1 performs the access, stage 2 forms read data.
    logic       accept_s;
    logic       s1_vld_r;
    logic [3:0] s1_adr_r;
    logic       s1_we_r;
    logic [7:0] s1_dat_r;
    logic       s2_vld_r;
    logic [3:0] s2_adr_r;
    logic       s2_we_r;
    logic       s2_start_r;
    logic       s2_in_range_r;

    // Programmable state.
    logic [11:0] ptr_r;
    logic        autoinc_r;
    logic [7:0]  fill_char_r;
    logic [7:0]  fill_attr_r;

    // Read data staging.
    logic [7:0] reg_rd_s;
    logic [7:0] reg_rd_r;
    logic [7:0] cpu_char_q_r;
    logic [7:0] cpu_attr_q_r;
    logic [7:0] rd_mux_s;

    logic ptr_in_range_s;
    logic cpu_char_wr_s;
    logic cpu_attr_wr_s;

    // Clear engine.
    clr_state_t  state_r;
    clr_state_t  state_s;
    logic [11:0] clr_cnt_r;
    logic [11:0] clr_cnt_s;
    logic        busy_s;
    logic        clr_wr_s;
    logic        load_fill_s;
    logic        start_s;
    logic [7:0]  clr_char_r;
    logic [7:0]  clr_attr_r;

    // Upper address bits are outside the decoded window.
    logic unused_adr_s;
    assign unused_adr_s = ^wb_adr_i[7:4];

    // An access is in flight from acceptance through its ack cycle.
    assign accept_s = wb_cyc_i & wb_stb_i & ~(s1_vld_r | s2_vld_r | wb_ack_o);

    assign ptr_in_range_s = (ptr_r < CELLS_W);
    // CPU cell writes are dropped while the clear engine owns the RAM.
    assign cpu_char_wr_s  = s1_vld_r & s1_we_r & (s1_adr_r == A_CHAR) & ptr_in_range_s & ~busy;
    assign cpu_attr_wr_s  = s1_vld_r & s1_we_r & (s1_adr_r == A_ATTR) & ptr_in_range_s & ~busy;
    assign start_s        = s2_vld_r & s2_start_r;

    // Bus handshake pipeline and registered read data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld_r   <= 1'b0;
            s1_adr_r   <= 4'h0;
            s1_we_r    <= 1'b0;
            s1_dat_r   <= 8'h00;
            s2_vld_r   <= 1'b0;
            s2_adr_r   <= 4'h0;
            s2_we_r    <= 1'b0;
            s2_start_r <= 1'b0;
            wb_ack_o   <= 1'b0;
            wb_dat_o   <= 8'h00;
        end else begin
            s1_vld_r <= accept_s;
            if (accept_s) begin
                s1_adr_r <= wb_adr_i[3:0];
                s1_we_r  <= wb_we_i;
                s1_dat_r <= wb_dat_i;
            end
            s2_vld_r <= s1_vld_r;
            if (s1_vld_r) begin
                s2_adr_r   <= s1_adr_r;
                s2_we_r    <= s1_we_r;
                s2_start_r <= s1_we_r & (s1_adr_r == A_CTRL) & s1_dat_r[1];
            end
            wb_ack_o <= s2_vld_r;
            if (s2_vld_r && !s2_we_r) begin
                wb_dat_o <= rd_mux_s;
            end
        end
    end

    // Register read mux, sampled while the access is in stage 1.
    always_comb begin
        reg_rd_s = 8'h00;
        case (s1_adr_r)
            A_PTR_LO:    reg_rd_s = ptr_r[7:0];
            A_PTR_HI:    reg_rd_s = {4'h0, ptr_r[11:8]};
            A_CTRL:      reg_rd_s = {7'h00, autoinc_r};
            A_STATUS:    reg_rd_s = {VERSION, 3'b000, busy};
            A_FILL_CHAR: reg_rd_s = fill_char_r;
            A_FILL_ATTR: reg_rd_s = fill_attr_r;
            default:     reg_rd_s = 8'h00;
        endcase
    end

    // Final read data: RAM cells return zero when the pointer was out of range.
    always_comb begin
        rd_mux_s = reg_rd_r;
        case (s2_adr_r)
            A_CHAR:  rd_mux_s = s2_in_range_r ? cpu_char_q_r : 8'h00;
            A_ATTR:  rd_mux_s = s2_in_range_r ? cpu_attr_q_r : 8'h00;
            default: rd_mux_s = reg_rd_r;
        endcase
    end

    // Register writes and pointer auto-increment, performed in stage 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_r         <= 12'h000;
            autoinc_r     <= 1'b1;
            fill_char_r   <= 8'h20;
            fill_attr_r   <= 8'h0F;
            reg_rd_r      <= 8'h00;
            s2_in_range_r <= 1'b0;
        end else if (s1_vld_r) begin
            reg_rd_r      <= reg_rd_s;
            s2_in_range_r <= ptr_in_range_s;
            if (s1_we_r) begin
                case (s1_adr_r)
                    A_PTR_LO:    ptr_r[7:0]  <= s1_dat_r;
                    A_PTR_HI:    ptr_r[11:8] <= s1_dat_r[3:0];
                    A_CTRL:      autoinc_r   <= s1_dat_r[0];
                    A_FILL_CHAR: fill_char_r <= s1_dat_r;
                    A_FILL_ATTR: fill_attr_r <= s1_dat_r;
                    default:     ;
                endcase
            end
            // Only CHAR advances the pointer; last or out-of-range cells wrap to 0.
            if ((s1_adr_r == A_CHAR) && autoinc_r) begin
                ptr_r <= (ptr_r >= LAST_CELL) ? 12'h000 : (ptr_r + 12'd1);
            end
        end
    end

    // Single RAM write port shared by the clear engine and CPU, plus CPU read capture.
    always_ff @(posedge clk) begin
        if (clr_wr_s) begin
            char_mem_r[clr_cnt_r] <= clr_char_r;
            attr_mem_r[clr_cnt_r] <= clr_attr_r;
        end else if (cpu_char_wr_s) begin
            char_mem_r[ptr_r] <= s1_dat_r;
        end else if (cpu_attr_wr_s) begin
            attr_mem_r[ptr_r] <= s1_dat_r;
        end
        if (s1_vld_r) begin
            cpu_char_q_r <= char_mem_r[ptr_r];
            cpu_attr_q_r <= attr_mem_r[ptr_r];
        end
    end

    // Video read port; a same-edge write leaves the old cell value visible here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            text_char_data <= 8'h00;
            text_attr_data <= 8'h00;
        end else if (text_char_addr < CELLS_W) begin
            text_char_data <= char_mem_r[text_char_addr];
            text_attr_data <= attr_mem_r[text_char_addr];
        end else begin
            text_char_data <= 8'h00;
            text_attr_data <= 8'h00;
        end
    end

    // Clear engine state register; fill pair latched at start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            clr_cnt_r  <= 12'h000;
            busy       <= 1'b0;
            clr_char_r <= 8'h00;
            clr_attr_r <= 8'h00;
        end else begin
            state_r   <= state_s;
            clr_cnt_r <= clr_cnt_s;
            busy      <= busy_s;
            if (load_fill_s) begin
                clr_char_r <= fill_char_r;
                clr_attr_r <= fill_attr_r;
            end
        end
    end

    // Clear engine next state: one cell per cycle, start requests ignored while clearing.
    always_comb begin
        state_s     = state_r;
        clr_cnt_s   = clr_cnt_r;
        busy_s      = busy;
        clr_wr_s    = 1'b0;
        load_fill_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    state_s     = ST_CLEAR;
                    clr_cnt_s   = 12'h000;
                    busy_s      = 1'b1;
                    load_fill_s = 1'b1;
                end else begin
                    busy_s = 1'b0;
                end
            end
            ST_CLEAR: begin
                clr_wr_s = 1'b1;
                if (clr_cnt_r == LAST_CELL) begin
                    state_s   = ST_IDLE;
                    clr_cnt_s = 12'h000;
                    busy_s    = 1'b0;
                end else begin
                    clr_cnt_s = clr_cnt_r + 12'd1;
                    busy_s    = 1'b1;
                end
            end
            default: begin
                state_s   = ST_IDLE;
                clr_cnt_s = 12'h000;
                busy_s    = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_wb_char_ram.sv
// Directed testbench for wb_char_ram with a read scoreboard.
module tb_wb_char_ram;

    logic        clk;
    logic        rst;
    logic [7:0]  wb_adr_i;
    logic [7:0]  wb_dat_i;
    logic [7:0]  wb_dat_o;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_we_i;
    logic        wb_ack_o;
    logic [11:0] text_char_addr;
    logic [7:0]  text_char_data;
    logic [7:0]  text_attr_data;
    logic        busy;

    int total = 0;
    int bad   = 0;
    int cyc_cnt = 0;
    int last_ack_cyc = 0;
    logic last_ack_busy = 1'b0;
    int t0 = 0;

    logic [7:0] exp_q [$];
    string      tag_q [$];

    wb_char_ram #(.COLS(80), .ROWS(30)) dut (
        .clk            (clk),
        .rst            (rst),
        .wb_adr_i       (wb_adr_i),
        .wb_dat_i       (wb_dat_i),
        .wb_dat_o       (wb_dat_o),
        .wb_cyc_i       (wb_cyc_i),
        .wb_stb_i       (wb_stb_i),
        .wb_we_i        (wb_we_i),
        .wb_ack_o       (wb_ack_o),
        .text_char_addr (text_char_addr),
        .text_char_data (text_char_data),
        .text_attr_data (text_attr_data),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One bus access; checks the 2-cycle ack latency and 1-cycle ack width.
    task automatic wb_xfer(input logic [7:0] adr, input logic we, input logic [7:0] dat,
                           output logic [7:0] rdat);
        int n;
        bit got;
        wb_adr_i = adr;
        wb_we_i  = we;
        wb_dat_i = dat;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        n   = 0;
        got = 1'b0;
        while (!got && n < 10) begin
            @(posedge clk);
            #1;
            n++;
            if (wb_ack_o === 1'b1) got = 1'b1;
        end
        rdat = wb_dat_o;
        last_ack_cyc  = cyc_cnt;
        last_ack_busy = busy;
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        chk("ack_latency", 32'(n), 32'd3);
        @(posedge clk);
        #1;
        chk("ack_width", {31'd0, wb_ack_o}, 32'd0);
    endtask

    task automatic wb_write(input logic [7:0] adr, input logic [7:0] dat);
        logic [7:0] r;
        wb_xfer(adr, 1'b1, dat, r);
    endtask

    task automatic wb_read(input logic [7:0] adr, input logic [7:0] exp, input string tag);
        logic [7:0] r;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        wb_xfer(adr, 1'b0, 8'h00, r);
        chk(tag_q.pop_front(), {24'd0, r}, {24'd0, exp_q.pop_front()});
    endtask

    task automatic set_ptr(input logic [11:0] p);
        wb_write(8'h00, p[7:0]);
        wb_write(8'h01, {4'h0, p[11:8]});
    endtask

    task automatic vid_check(input logic [11:0] a, input logic [7:0] ec, input logic [7:0] ea,
                             input string tag);
        text_char_addr = a;
        @(posedge clk);
        #1;
        chk({tag, "_char"}, {24'd0, text_char_data}, {24'd0, ec});
        chk({tag, "_attr"}, {24'd0, text_attr_data}, {24'd0, ea});
    endtask

    initial begin
        rst = 1'b1;
        wb_adr_i = 8'h00;
        wb_dat_i = 8'h00;
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        text_char_addr = 12'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack",  {31'd0, wb_ack_o}, 32'd0);
        chk("rst_dat",  {24'd0, wb_dat_o}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_vchar", {24'd0, text_char_data}, 32'd0);
        chk("rst_vattr", {24'd0, text_attr_data}, 32'd0);
        rst = 1'b0;

        // 1: reset register values
        wb_read(8'h04, 8'h01, "ctrl_reset");
        wb_read(8'h05, 8'h10, "status_reset");
        wb_read(8'h06, 8'h20, "fill_char_reset");
        wb_read(8'h07, 8'h0F, "fill_attr_reset");
        wb_read(8'h00, 8'h00, "ptr_lo_reset");
        wb_write(8'h0A, 8'h5A);
        wb_read(8'h0A, 8'h00, "reserved_read");

        // 2: ATTR then CHAR per cell with auto-increment
        set_ptr(12'd0);
        wb_write(8'h03, 8'h1E);
        wb_write(8'h02, 8'h41);
        wb_write(8'h03, 8'h1E);
        wb_write(8'h02, 8'h42);
        wb_read(8'h00, 8'h02, "ptr_after_two_cells");
        vid_check(12'd0, 8'h41, 8'h1E, "vid_cell0");
        vid_check(12'd1, 8'h42, 8'h1E, "vid_cell1");

        // 3: last cell wraps pointer; PTR_HI upper nibble reads 0
        set_ptr(12'd2399);
        wb_write(8'h01, 8'hF9);
        wb_read(8'h01, 8'h09, "ptr_hi_nibble");
        wb_write(8'h03, 8'h07);
        wb_write(8'h02, 8'h5A);
        wb_read(8'h00, 8'h00, "wrap_ptr_lo");
        wb_read(8'h01, 8'h00, "wrap_ptr_hi");
        vid_check(12'd2399, 8'h5A, 8'h07, "vid_last");

        // 4: out-of-range pointer
        set_ptr(12'd2400);
        wb_write(8'h02, 8'h33);
        wb_read(8'h00, 8'h00, "oor_wrap_lo");
        wb_read(8'h01, 8'h00, "oor_wrap_hi");
        set_ptr(12'd2400);
        wb_read(8'h02, 8'h00, "oor_char_read");
        vid_check(12'd2400, 8'h00, 8'h00, "vid_oor");
        vid_check(12'd0, 8'h41, 8'h1E, "vid_cell0_kept");

        // 5: clear with a dropped write and an ignored restart
        wb_write(8'h06, 8'h2E);
        wb_write(8'h07, 8'h70);
        wb_write(8'h04, 8'h03);
        chk("busy_at_ack", {31'd0, last_ack_busy}, 32'd1);
        t0 = last_ack_cyc;
        set_ptr(12'd5);
        wb_write(8'h02, 8'h99);
        wb_read(8'h00, 8'h06, "autoinc_while_busy");
        wb_write(8'h04, 8'h03);
        while (busy === 1'b1 && cyc_cnt < t0 + 3000) begin
            @(posedge clk);
            #1;
        end
        chk("busy_length", 32'(cyc_cnt - t0), 32'd2400);
        repeat (5) @(posedge clk);
        #1;
        chk("busy_stays_low", {31'd0, busy}, 32'd0);
        set_ptr(12'd5);
        wb_read(8'h02, 8'h2E, "cpu_cell5_cleared");
        for (int i = 0; i < 2400; i++) begin
            vid_check(12'(i), 8'h2E, 8'h70, "vid_clear");
        end

        // 6: reset in the middle of a clear
        wb_write(8'h06, 8'h55);
        wb_write(8'h07, 8'hAA);
        wb_read(8'h06, 8'h55, "fill_char_new");
        text_char_addr = 12'd0;
        wb_write(8'h04, 8'h03);
        t0 = last_ack_cyc;
        while (cyc_cnt < t0 + 1000) begin
            @(posedge clk);
            #1;
        end
        chk("pre_rst_vchar", {24'd0, text_char_data}, 32'h55);
        rst = 1'b1;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_dat", {24'd0, wb_dat_o}, 32'd0);
        chk("abort_vchar", {24'd0, text_char_data}, 32'd0);
        chk("abort_vattr", {24'd0, text_attr_data}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_busy_after", {31'd0, busy}, 32'd0);
        vid_check(12'd0,    8'h55, 8'hAA, "abort_cell0");
        vid_check(12'd999,  8'h55, 8'hAA, "abort_cell999");
        vid_check(12'd1000, 8'h2E, 8'h70, "abort_cell1000");
        vid_check(12'd2399, 8'h2E, 8'h70, "abort_cell2399");
        wb_read(8'h06, 8'h20, "abort_fill_char");
        wb_read(8'h04, 8'h01, "abort_ctrl");
        wb_read(8'h00, 8'h00, "abort_ptr");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_char_ram.md
Name: wb_char_ram

Overview:
Text-mode character/attribute store feeding the HDMI video control block's character interface. It is a Wishbone slave at base 0x20-0x2F. The CPU accesses it through a pointer register with optional auto-increment. A hardware clear engine fills the screen. Video reads use a dedicated read port with fixed 1-cycle latency.

Parameters:
COLS, 80, characters per row
ROWS, 30, rows per screen
CELLS, COLS*ROWS (2400), number of valid cells; addresses 0..CELLS-1

Ports:
clk  in  1  system clock (Wishbone and video share it)
rst  in  1  asynchronous active-high reset
wb_adr_i  in  8  Wishbone address; only [3:0] decoded
wb_dat_i  in  8  write data
wb_dat_o  out  8  read data
wb_cyc_i  in  1  bus cycle
wb_stb_i  in  1  strobe
wb_we_i  in  1  write enable
wb_ack_o  out  1  acknowledge
text_char_addr  in  12  video cell address
text_char_data  out  8  character code at text_char_addr
text_attr_data  out  8  attribute at text_char_addr
busy  out  1  clear engine running

Behaviour:
- Reset (async, rst=1): wb_ack_o=0, wb_dat_o=0x00, text_char_data=0x00, text_attr_data=0x00, busy=0, ptr=0, ctrl.autoinc=1, fill_char=0x20, fill_attr=0x0F. RAM contents are not reset.
- Register map (wb_adr_i[3:0]):
  - 0x0 PTR_LO (R/W, ptr[7:0]).
  - 0x1 PTR_HI (R/W, ptr[11:8]; reads return upper nibble 0).
  - 0x2 CHAR (R/W char RAM at ptr).
  - 0x3 ATTR (R/W attr RAM at ptr).
  - 0x4 CTRL: bit0 autoinc (R/W); bit1 write-1 starts clear (reads 0).
  - 0x5 STATUS (RO): bit0 busy, bits7:4 = 0x1 version.
  - 0x6 FILL_CHAR (R/W).
  - 0x7 FILL_ATTR (R/W).
  - 0x8-0xF: reads 0x00, writes ignored, still acked.
- Handshake:
  - valid = cyc & stb.
  - Access is accepted on the first edge with valid=1 and no access in flight.
  - wb_ack_o pulses high for exactly one cycle, two cycles after acceptance. This is a fixed 2-cycle latency for all registers.
  - wb_dat_o is valid in the ack cycle and holds until the next read.
  - The master holds signals until ack. No new acceptance occurs in the ack cycle.
- Auto-increment:
  - Applies only when autoinc=1, only after a CHAR (0x2) access, read or write.
  - ATTR accesses never increment, so software writes ATTR then CHAR per cell.
  - ptr = CELLS-1 increments to 0.
  - The increment is visible to the next access.
- Out-of-range ptr (>= CELLS): CHAR/ATTR writes are discarded, reads return 0x00, auto-increment wraps to 0.
- Clear engine, states IDLE -> CLEAR -> IDLE:
  - CTRL bit1 write in IDLE sets busy=1 on the ack cycle.
  - CLEAR writes fill_char/fill_attr to one cell per cycle, from cell 0 to CELLS-1 (CELLS cycles).
  - After the last cell, the engine returns to IDLE and busy=0 the next cycle.
  - Fill values are sampled at start; later FILL writes do not affect a running clear.
  - Start request while busy: ignored.
  - ptr is unchanged by a clear.
- CPU access during busy:
  - Acked normally.
  - CHAR/ATTR writes are dropped.
  - CHAR/ATTR reads return the current RAM contents.
  - Auto-increment still applies.
- Video port:
  - text_char_data/attr are registered, showing the RAM contents at text_char_addr sampled on the previous edge (1-cycle latency).
  - Address >= CELLS outputs 0x00/0x00.
  - Video reads never stall and are never blocked by CPU or clear writes.
  - Same-cycle write/read of one cell: video returns the old data.
- rst asserted mid-clear: the engine aborts immediately, busy=0, and partially cleared RAM is left as-is.

Test Plan:
1. Reset, then read 0x4/0x5/0x6/0x7 -> 0x01, 0x10, 0x20, 0x0F; every ack is exactly 1 cycle, 2 cycles after acceptance.
2. PTR=0, autoinc=1, write ATTR 0x1E then CHAR 0x41, repeat at cell 1 with CHAR 0x42. Then drive text_char_addr=0 and 1 -> char/attr 0x41/0x1E, then 0x42/0x1E, one cycle after each address.
3. PTR=2399, write CHAR 0x5A -> PTR reads back 0x000; text_char_addr=2399 -> 0x5A.
4. PTR=2400, write CHAR 0x33, read CHAR -> 0x00; text_char_addr=2400 -> 0x00; PTR reads back 0 after the write-induced wrap.
5. FILL_CHAR=0x2E, FILL_ATTR=0x70, start clear; mid-clear, write CHAR 0x99 at cell 5 and re-issue start -> busy high for 2400 cycles; all cells read 0x2E/0x70, cell 5 included; second start ignored.
6. Assert rst at cycle 1000 of a clear -> busy=0 immediately, outputs return to reset values, cells 0-999 hold fill values, remaining cells hold prior contents.
